// File: rtl/spi_sensor_poller.sv
// spi_sensor_poller
//   Autonomous bus master for spi_master_if (16-bit frames). Every PERIOD clk
//   cycles it runs one burst of NUM_REGS+1 SPI frames against an ADIS-style
//   sensor. The sensor pipelines its answers, so the reply to command k arrives
//   in frame k+1. Replies are collected in a shadow bank and copied to the
//   CPU-visible bank in a single cycle once the whole burst has succeeded.
//
// Ports
//   clk, reset_n                  system clock, asynchronous active-low reset
//   enable                        1 = periodic bursts run; 0 = finish burst, then idle
//   spi_select, read_n, write_n   two-cycle slave access strobes to spi_master_if
//   mem_addr, spi_wr_data         register address (0 = rx, 1 = tx) and tx data
//   spi_rd_data                   rx data from spi_master_if
//   readyfordata, dataavailable   TRDY / RRDY status from spi_master_if
//   rd_idx, rd_data               CPU read port of the result bank (combinational)
//   sample_valid                  1-cycle pulse when a burst has been committed
//   busy                          a burst is in progress
//   timeout_err, overrun_err      sticky error flags, cleared by err_clr
module spi_sensor_poller #(
  parameter int unsigned NUM_REGS  = 8,
  parameter logic [7:0]  BASE_ADDR = 8'h04,
  parameter int unsigned PERIOD    = 40000,
  parameter int unsigned STALL     = 360,
  parameter int unsigned TIMEOUT   = 2047
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        spi_select,
  output logic        read_n,
  output logic        write_n,
  output logic [2:0]  mem_addr,
  output logic [15:0] spi_wr_data,
  input  logic [15:0] spi_rd_data,
  input  logic        readyfordata,
  input  logic        dataavailable,
  input  logic [3:0]  rd_idx,
  output logic [15:0] rd_data,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun_err,
  input  logic        err_clr
);

  localparam int unsigned PW   = $clog2(PERIOD);
  localparam int unsigned CMAX = (STALL > TIMEOUT) ? STALL : TIMEOUT;
  localparam int unsigned CW   = $clog2(CMAX + 2);
  localparam int unsigned IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FLUSH, S_FLUSH_RD, S_WAIT_T, S_WR, S_WAIT_R, S_RD, S_STALL, S_COMMIT
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    frame_q, frame_d;
  logic          timeout_err_q, timeout_err_d;
  logic          overrun_err_q, overrun_err_d;
  logic [15:0]   shadow_q [NUM_REGS];
  logic [15:0]   bank_q   [NUM_REGS];

  logic          tick, last_frame, acc_done, wait_expired, stall_done;
  logic          timeout_set, store, commit;
  logic [6:0]    addr_f;
  logic [15:0]   tx_word;
  logic [IW-1:0] shadow_idx;

  assign tick         = enable && (per_q == PW'(PERIOD - 1));
  assign last_frame   = (frame_q == 5'(NUM_REGS));
  // cnt_q is cleared on every state change, so it doubles as the access
  // phase, the stall timer and the readiness timeout counter.
  assign acc_done     = (cnt_q == CW'(1));
  assign wait_expired = (cnt_q == CW'(TIMEOUT - 1));
  assign stall_done   = (32'(cnt_q) + 32'd1) >= STALL;
  assign addr_f       = 7'(BASE_ADDR + {2'b00, frame_q, 1'b0});
  assign tx_word      = last_frame ? 16'h0000 : {1'b0, addr_f, 8'h00};
  assign shadow_idx   = IW'(frame_q - 5'd1);

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d      = state_q;
    frame_d      = frame_q;
    timeout_set  = 1'b0;
    store        = 1'b0;
    commit       = 1'b0;
    spi_select   = 1'b0;
    read_n       = 1'b1;
    write_n      = 1'b1;
    mem_addr     = 3'd0;
    spi_wr_data  = 16'h0000;
    sample_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        frame_d = 5'd0;
        if (tick) state_d = S_FLUSH;
      end
      // A reply left over from before the burst would shift every result by
      // one register, so drain it first.
      S_FLUSH: state_d = dataavailable ? S_FLUSH_RD : S_WAIT_T;
      S_FLUSH_RD: begin
        spi_select = 1'b1;
        read_n     = 1'b0;
        if (acc_done) state_d = S_WAIT_T;
      end
      S_WAIT_T: begin
        if (readyfordata) begin
          state_d = S_WR;
        end else if (wait_expired) begin
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WR: begin
        spi_select  = 1'b1;
        write_n     = 1'b0;
        mem_addr    = 3'd1;
        spi_wr_data = tx_word;
        if (acc_done) state_d = S_WAIT_R;
      end
      S_WAIT_R: begin
        if (dataavailable) begin
          state_d = S_RD;
        end else if (wait_expired) begin
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_RD: begin
        spi_select = 1'b1;
        read_n     = 1'b0;
        if (acc_done) begin
          // Frame 0 carries the reply to a command from before this burst.
          store   = (frame_q != 5'd0);
          state_d = S_STALL;
        end
      end
      S_STALL: begin
        if (stall_done) begin
          if (last_frame) begin
            state_d = S_COMMIT;
          end else begin
            frame_d = frame_q + 5'd1;
            state_d = S_WAIT_T;
          end
        end
      end
      S_COMMIT: begin
        commit       = 1'b1;
        sample_valid = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + CW'(1);
    per_d = (!enable || tick) ? '0 : per_q + PW'(1);
    // A set in the same cycle as err_clr wins.
    timeout_err_d = timeout_set | (timeout_err_q & ~err_clr);
    overrun_err_d = (tick && state_q != S_IDLE) | (overrun_err_q & ~err_clr);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      per_q         <= '0;
      cnt_q         <= '0;
      frame_q       <= 5'd0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_q         <= per_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // NOTE: the shadow bank has no reset: each entry is rewritten before any
  // commit can read it, so a reset would only cost routing. The visible bank
  // must read 0 after reset and is therefore reset.
  always_ff @(posedge clk) begin
    if (store) shadow_q[shadow_idx] <= spi_rd_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) bank_q[i] <= 16'h0000;
    end else if (commit) begin
      bank_q <= shadow_q;
    end
  end

  assign rd_data     = (32'(rd_idx) < NUM_REGS) ? bank_q[IW'(rd_idx)] : 16'h0000;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_spi_sensor_poller.sv
// Self-checking bench for spi_sensor_poller. A behavioural stand-in for
// spi_master_if plus a pipelined sensor (reply to command k returned in the
// following frame) answers the main instance; a second instance with a short
// period and no slave response exercises the overrun flag.
module tb_spi_sensor_poller;

  localparam int         N    = 8;
  localparam logic [7:0] BASE = 8'h04;
  localparam int         PER  = 2000;
  localparam int         STL  = 20;
  localparam int         TO   = 2047;

  logic        clk, reset_n, enable, err_clr;
  logic        spi_select, read_n, write_n;
  logic [2:0]  mem_addr;
  logic [15:0] spi_wr_data, spi_rd_data, rd_data;
  logic        readyfordata, dataavailable;
  logic [3:0]  rd_idx;
  logic        sample_valid, busy, timeout_err, overrun_err;

  logic        enable_f, err_clr_f;
  logic        sel_f, rdn_f, wrn_f, sv_f, busy_f, toerr_f, overrun_f;
  logic [2:0]  addr_f;
  logic [15:0] wdata_f, rdata_f;

  int checks = 0;
  int failures = 0;

  spi_sensor_poller #(.NUM_REGS(N), .BASE_ADDR(BASE), .PERIOD(PER), .STALL(STL), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .spi_select(spi_select), .read_n(read_n), .write_n(write_n), .mem_addr(mem_addr),
    .spi_wr_data(spi_wr_data), .spi_rd_data(spi_rd_data),
    .readyfordata(readyfordata), .dataavailable(dataavailable),
    .rd_idx(rd_idx), .rd_data(rd_data), .sample_valid(sample_valid), .busy(busy),
    .timeout_err(timeout_err), .overrun_err(overrun_err), .err_clr(err_clr)
  );

  spi_sensor_poller #(.NUM_REGS(N), .BASE_ADDR(BASE), .PERIOD(16), .STALL(0), .TIMEOUT(TO)) u_fast (
    .clk(clk), .reset_n(reset_n), .enable(enable_f),
    .spi_select(sel_f), .read_n(rdn_f), .write_n(wrn_f), .mem_addr(addr_f),
    .spi_wr_data(wdata_f), .spi_rd_data(16'h0000),
    .readyfordata(1'b0), .dataavailable(1'b0),
    .rd_idx(4'd0), .rd_data(rdata_f), .sample_valid(sv_f), .busy(busy_f),
    .timeout_err(toerr_f), .overrun_err(overrun_f), .err_clr(err_clr_f)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- slave + sensor model ----------------
  logic [15:0] sens_tab [128];   // sensor register contents, owned by the tests
  bit          hold_miso = 1'b0; // freezes transfers in flight
  int          stale_req = 0, abort_req = 0;

  logic [15:0] rx_reg = 16'h0, sens_pipe = 16'h0, cur_cmd = 16'h0, acc_data = 16'h0;
  logic [2:0]  acc_addr = 3'd0;
  bit          trdy = 1'b1, rrdy = 1'b0, acc_wr = 1'b0;
  int          low_cnt = 0, xfer_left = 0, stale_ack = 0, abort_ack = 0;
  int          proto_err = 0, toe = 0, wr_cnt = 0, rd_cnt = 0, sv_cnt = 0;
  longint      cyc = 0, t_wr = 0;
  logic [15:0] tx_log [$];

  assign spi_rd_data   = rx_reg;
  assign readyfordata  = trdy;
  assign dataavailable = rrdy;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      low_cnt = 0; trdy = 1'b1; rrdy = 1'b0; rx_reg = 16'h0; sens_pipe = 16'h0; xfer_left = 0;
    end else begin
      if (stale_req != stale_ack) begin
        rx_reg = 16'hDEAD; rrdy = 1'b1; stale_ack = stale_req;
      end
      if (abort_req != abort_ack) begin
        xfer_left = 0; trdy = 1'b1; rrdy = 1'b0; abort_ack = abort_req;
      end
      if (xfer_left > 0 && !hold_miso) begin
        xfer_left--;
        if (xfer_left == 0) begin
          rx_reg    = sens_pipe;
          sens_pipe = sens_tab[cur_cmd[14:8]];
          rrdy      = 1'b1;
          trdy      = 1'b1;
        end
      end
      if (sample_valid) sv_cnt++;
      if (spi_select && (!read_n || !write_n)) begin
        if (!read_n && !write_n) proto_err++;
        if (low_cnt == 0) begin
          acc_addr = mem_addr; acc_wr = !write_n; acc_data = spi_wr_data;
        end else if (mem_addr != acc_addr || spi_wr_data != acc_data || acc_wr != !write_n) begin
          proto_err++;
        end
        low_cnt++;
        if (low_cnt == 2) begin
          if (acc_wr) begin
            if (mem_addr != 3'd1) proto_err++;
            if (!trdy) toe++;
            trdy      = 1'b0;
            cur_cmd   = spi_wr_data;
            xfer_left = 30 + int'($urandom_range(0, 8));
            tx_log.push_back(spi_wr_data);
            wr_cnt++;
            t_wr = cyc;
          end else begin
            if (mem_addr != 3'd0) proto_err++;
            rrdy = 1'b0;
            rd_cnt++;
          end
        end
      end else begin
        if (low_cnt != 0 && low_cnt != 2) proto_err++;
        low_cnt = 0;
      end
    end
  end

  // ---------------- reference helpers ----------------
  logic [15:0] exp_bank [N];

  function automatic logic [15:0] exp_tx(int f);
    logic [7:0] a;
    if (f == N) return 16'h0000;
    a = BASE + 8'(2 * f);
    return {1'b0, a[6:0], 8'h00};
  endfunction

  function automatic logic [15:0] exp_reg(int k);
    logic [7:0] a;
    a = BASE + 8'(2 * k);
    return sens_tab[a[6:0]];
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_burst(output bit done);
    int base;
    base = sv_cnt;
    done = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < PER + 2000; i++) begin
      step();
      if (sv_cnt != base) begin
        done = 1'b1;
        break;
      end
    end
    enable = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step();
    checks++; if ({spi_select, read_n, write_n} !== 3'b011) begin failures++; $display("FAIL reset_strobes got=%b want=011", {spi_select, read_n, write_n}); end
    checks++; if ({mem_addr, spi_wr_data} !== 19'h0) begin failures++; $display("FAIL reset_bus got=%h want=0", {mem_addr, spi_wr_data}); end
    checks++; if ({sample_valid, busy, timeout_err, overrun_err} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b want=0000", {sample_valid, busy, timeout_err, overrun_err}); end
    checks++; if ({sel_f, rdn_f, wrn_f, busy_f, overrun_f} !== 5'b01100) begin failures++; $display("FAIL reset_fast got=%b want=01100", {sel_f, rdn_f, wrn_f, busy_f, overrun_f}); end
    reset_n = 1'b1;
    for (int j = 0; j < 16; j++) begin
      rd_idx = 4'(j);
      step();
      checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL reset_bank idx=%0d got=%h want=0000", j, rd_data); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b want=0", busy); end
  endtask

  task automatic test_burst();
    bit done;
    int tx_base, sv_base, start, idx;
    logic [15:0] want;
    for (int a = 0; a < 128; a++) sens_tab[a] = 16'hA000 | 16'(a);
    tx_base = tx_log.size();
    sv_base = sv_cnt;
    run_burst(done);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL burst_done got=%b want=1", done); end
    for (int k = 0; k < N; k++) exp_bank[k] = exp_reg(k);
    checks++; if (tx_log.size() - tx_base !== N + 1) begin failures++; $display("FAIL burst_nwrites got=%0d want=%0d", tx_log.size() - tx_base, N + 1); end
    for (int f = 0; f <= N && tx_base + f < tx_log.size(); f++) begin
      checks++; if (tx_log[tx_base + f] !== exp_tx(f)) begin failures++; $display("FAIL burst_tx f=%0d got=%h want=%h", f, tx_log[tx_base + f], exp_tx(f)); end
    end
    start = int'($urandom_range(0, 15));
    for (int j = 0; j < 16; j++) begin
      idx = (start + 7 * j) % 16;
      rd_idx = 4'(idx);
      step();
      want = (idx < N) ? exp_bank[idx] : 16'h0;
      checks++; if (rd_data !== want) begin failures++; $display("FAIL burst_bank idx=%0d got=%h want=%h", idx, rd_data, want); end
    end
    checks++; if (sv_cnt - sv_base !== 1) begin failures++; $display("FAIL burst_pulses got=%0d want=1", sv_cnt - sv_base); end
    checks++; if (proto_err !== 0) begin failures++; $display("FAIL burst_protocol errors=%0d want=0", proto_err); end
    checks++; if (toe !== 0) begin failures++; $display("FAIL burst_toe got=%0d want=0", toe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_idle busy=%b want=0", busy); end
  endtask

  task automatic test_flush();
    bit done;
    int rd_base;
    logic [15:0] v;
    for (int a = 0; a < 128; a++) begin
      v = 16'($urandom);
      sens_tab[a] = (v == 16'hDEAD) ? 16'hBEEF : v;
    end
    stale_req++;
    step();
    checks++; if (dataavailable !== 1'b1) begin failures++; $display("FAIL flush_preset rrdy=%b want=1", dataavailable); end
    rd_base = rd_cnt;
    run_burst(done);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL flush_done got=%b want=1", done); end
    checks++; if (rd_cnt - rd_base !== N + 2) begin failures++; $display("FAIL flush_reads got=%0d want=%0d", rd_cnt - rd_base, N + 2); end
    for (int k = 0; k < N; k++) exp_bank[k] = exp_reg(k);
    for (int k = 0; k < N; k++) begin
      rd_idx = 4'(k);
      step();
      checks++; if (rd_data !== exp_bank[k]) begin failures++; $display("FAIL flush_bank idx=%0d got=%h want=%h", k, rd_data, exp_bank[k]); end
    end
    checks++; if (proto_err !== 0) begin failures++; $display("FAIL flush_protocol errors=%0d want=0", proto_err); end
  endtask

  task automatic test_timeout();
    bit seen_busy, seen_err;
    int sv_base, wr_base;
    longint delta;
    sv_base = sv_cnt;
    wr_base = wr_cnt;
    hold_miso = 1'b1;
    enable = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < PER + 10; i++) begin
      step();
      if (busy) begin seen_busy = 1'b1; break; end
    end
    enable = 1'b0;
    checks++; if (seen_busy !== 1'b1) begin failures++; $display("FAIL timeout_start busy=%b want=1", seen_busy); end
    seen_err = 1'b0;
    for (int i = 0; i < TO + 100; i++) begin
      step();
      if (timeout_err) begin seen_err = 1'b1; break; end
    end
    delta = cyc - t_wr;
    checks++; if (seen_err !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b want=1", seen_err); end
    checks++; if (delta < TO || delta > TO + 2) begin failures++; $display("FAIL timeout_latency got=%0d want=%0d..%0d", delta, TO, TO + 2); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_idle busy=%b want=0", busy); end
    checks++; if (wr_cnt - wr_base !== 1) begin failures++; $display("FAIL timeout_writes got=%0d want=1", wr_cnt - wr_base); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL timeout_overrun got=%b want=0", overrun_err); end
    for (int k = 0; k < N; k++) begin
      rd_idx = 4'(k);
      step();
      checks++; if (rd_data !== exp_bank[k]) begin failures++; $display("FAIL timeout_bank idx=%0d got=%h want=%h", k, rd_data, exp_bank[k]); end
    end
    checks++; if (sv_cnt !== sv_base) begin failures++; $display("FAIL timeout_pulses got=%0d want=0", sv_cnt - sv_base); end
    hold_miso = 1'b0;
    abort_req++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b want=0", timeout_err); end
  endtask

  // Edges counted from enable_f: ticks on edges 16, 32, 48.
  task automatic test_overrun();
    step();
    enable_f = 1'b1;
    repeat (20) step();
    checks++; if ({busy_f, overrun_f} !== 2'b10) begin failures++; $display("FAIL overrun_first_tick busy,ovr=%b want=10", {busy_f, overrun_f}); end
    repeat (20) step();
    checks++; if ({busy_f, overrun_f} !== 2'b11) begin failures++; $display("FAIL overrun_set busy,ovr=%b want=11", {busy_f, overrun_f}); end
    err_clr_f = 1'b1;
    step();
    err_clr_f = 1'b0;
    checks++; if (overrun_f !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b want=0", overrun_f); end
    repeat (6) step();
    checks++; if (overrun_f !== 1'b0) begin failures++; $display("FAIL overrun_quiet got=%b want=0", overrun_f); end
    err_clr_f = 1'b1;
    step();
    err_clr_f = 1'b0;
    checks++; if (overrun_f !== 1'b1) begin failures++; $display("FAIL overrun_set_wins got=%b want=1", overrun_f); end
    checks++; if (toerr_f !== 1'b0) begin failures++; $display("FAIL overrun_no_timeout got=%b want=0", toerr_f); end
    enable_f = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found, done;
    int wr_base, tx_base, perr_base, toe_base;
    for (int a = 0; a < 128; a++) sens_tab[a] = 16'hA000 | 16'(a);
    rd_idx = 4'($urandom_range(0, N - 1));
    wr_base = wr_cnt;
    found = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < PER + 2000; i++) begin
      step();
      if (wr_cnt - wr_base == 3 && write_n == 1'b0) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL rstmid_frame3 got=%b want=1", found); end
    #2 reset_n = 1'b0;
    enable = 1'b0;
    #1;
    checks++; if ({spi_select, read_n, write_n} !== 3'b011) begin failures++; $display("FAIL rstmid_strobes got=%b want=011", {spi_select, read_n, write_n}); end
    checks++; if ({busy, mem_addr, spi_wr_data} !== 20'h0) begin failures++; $display("FAIL rstmid_bus got=%h want=0", {busy, mem_addr, spi_wr_data}); end
    checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL rstmid_bank got=%h want=0000", rd_data); end
    for (int k = 0; k < N; k++) exp_bank[k] = 16'h0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    tx_base = tx_log.size();
    perr_base = proto_err;
    toe_base = toe;
    run_burst(done);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rstmid_done got=%b want=1", done); end
    checks++; if (tx_log.size() - tx_base !== N + 1) begin failures++; $display("FAIL rstmid_nwrites got=%0d want=%0d", tx_log.size() - tx_base, N + 1); end
    for (int f = 0; f <= N && tx_base + f < tx_log.size(); f++) begin
      checks++; if (tx_log[tx_base + f] !== exp_tx(f)) begin failures++; $display("FAIL rstmid_tx f=%0d got=%h want=%h", f, tx_log[tx_base + f], exp_tx(f)); end
    end
    for (int k = 0; k < N; k++) exp_bank[k] = exp_reg(k);
    for (int k = 0; k < N; k++) begin
      rd_idx = 4'(k);
      step();
      checks++; if (rd_data !== exp_bank[k]) begin failures++; $display("FAIL rstmid_bank idx=%0d got=%h want=%h", k, rd_data, exp_bank[k]); end
    end
    checks++; if (proto_err - perr_base !== 0 || toe - toe_base !== 0) begin failures++; $display("FAIL rstmid_protocol proto=%0d toe=%0d want=0", proto_err - perr_base, toe - toe_base); end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    err_clr   = 1'b0;
    rd_idx    = 4'd0;
    enable_f  = 1'b0;
    err_clr_f = 1'b0;
    for (int a = 0; a < 128; a++) sens_tab[a] = 16'h0;
    repeat (3) step();
    test_reset();
    test_burst();
    test_flush();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
